// File: rtl/sp_ctrl.sv
// Stack sequencer: owns the SP register through SPDrive/SPSet and a single-port
// data memory, serving PUSH/POP/PEEK/LOAD requests with stack-bounds checking.
module sp_ctrl #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] STACK_BASE  = WIDTH'(32'h0000_1000),
  parameter logic [WIDTH-1:0] STACK_LIMIT = WIDTH'(32'h0000_0F00)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_data,
  output logic             op_ready,
  output logic             done,
  output logic [1:0]       err,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       SPDrive,
  output logic [WIDTH-1:0] SPSet,
  input  logic [WIDTH-1:0] SPOutput,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  localparam logic [1:0] DRV_HOLD = 2'b00;
  localparam logic [1:0] DRV_INC  = 2'b01;
  localparam logic [1:0] DRV_DEC  = 2'b10;
  localparam logic [1:0] DRV_LOAD = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UDF = 2'b10;
  localparam logic [1:0] ERR_RNG = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DEC,
    S_WR,
    S_RD,
    S_INC,
    S_LD,
    S_RESP
  } state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             op_ready_q;
  logic             done_q;
  logic [1:0]       err_q;
  logic [WIDTH-1:0] rdata_q;
  logic [1:0]       spdrive_q;
  logic [WIDTH-1:0] spset_q;
  logic             mem_req_q;
  logic             mem_we_q;
  logic [WIDTH-1:0] mem_addr_q;
  logic [WIDTH-1:0] mem_wdata_q;
  logic [1:0]       fault_d;

  // Bounds check of the request presented at accept, against the live SP.
  always_comb begin
    fault_d = ERR_OK;
    case (op_code)
      OP_PUSH: if (SPOutput == STACK_LIMIT) fault_d = ERR_OVF;
      OP_POP,
      OP_PEEK: if (SPOutput == STACK_BASE) fault_d = ERR_UDF;
      default: if ((op_data < STACK_LIMIT) || (op_data > STACK_BASE)) fault_d = ERR_RNG;
    endcase
  end

  // Sequencer; every output is a flop set up on entry to the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      op_q        <= OP_PUSH;
      data_q      <= '0;
      op_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      rdata_q     <= '0;
      spdrive_q   <= DRV_HOLD;
      spset_q     <= STACK_BASE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
      spdrive_q <= DRV_HOLD;
      case (state_q)
        // The load is driven for one cycle after reset release, then IDLE.
        S_INIT: begin
          if (spdrive_q == DRV_LOAD) begin
            state_q    <= S_IDLE;
            op_ready_q <= 1'b1;
          end else begin
            spdrive_q <= DRV_LOAD;
            spset_q   <= STACK_BASE;
          end
        end
        S_IDLE: begin
          if (op_valid && op_ready_q) begin
            op_ready_q <= 1'b0;
            op_q       <= op_code;
            data_q     <= op_data;
            if (fault_d != ERR_OK) begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              err_q   <= fault_d;
            end else begin
              case (op_code)
                OP_PUSH: begin
                  state_q   <= S_DEC;
                  spdrive_q <= DRV_DEC;
                end
                OP_LOAD: begin
                  state_q   <= S_LD;
                  spdrive_q <= DRV_LOAD;
                  spset_q   <= op_data;
                end
                default: begin
                  state_q    <= S_RD;
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= SPOutput;
                end
              endcase
            end
          end
        end
        // SP decrements on this same edge, so the write targets SP-1.
        S_DEC: begin
          state_q     <= S_WR;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= SPOutput - WIDTH'(1);
          mem_wdata_q <= data_q;
        end
        S_WR: begin
          if (mem_ack) begin
            state_q   <= S_RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_RD: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            rdata_q   <= mem_rdata;
            if (op_q == OP_POP) begin
              state_q   <= S_INC;
              spdrive_q <= DRV_INC;
            end else begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
            end
          end
        end
        S_INC, S_LD: begin
          state_q <= S_RESP;
          done_q  <= 1'b1;
        end
        S_RESP: begin
          state_q    <= S_IDLE;
          op_ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign op_ready  = op_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign SPDrive   = spdrive_q;
  assign SPSet     = spset_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sp_ctrl.sv
// Bench for sp_ctrl: SP register and memory models around the DUT, directed
// scenarios plus random ops checked against an abstract stack model.
module tb_sp_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = 32'h0000_0F00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_data = '0;
  logic        op_ready, done, mem_req, mem_we, mem_ack;
  logic [1:0]  err, SPDrive;
  logic [31:0] rdata, SPSet, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] sp_reg = '0;

  logic [31:0] mem [0:8191];
  int          wait_cnt = 0;
  int          ack_delay = 0;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model state
  logic [31:0] sp_m, rdata_m;
  logic [31:0] mm [0:8191];

  // Expected / observed per op
  int          e_lat, e_nreq, o_lat, o_nreq;
  logic [1:0]  e_err, o_err;
  logic [31:0] e_rdata, e_sp, e_addr, e_wdata, o_rdata, o_sp, o_addr, o_wdata;
  logic        e_we, o_we, o_stable, o_proto, o_ready_after;

  sp_ctrl dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_code(op_code), .op_data(op_data),
    .op_ready(op_ready), .done(done), .err(err), .rdata(rdata),
    .SPDrive(SPDrive), .SPSet(SPSet), .SPOutput(sp_reg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (SPDrive)
      2'b01:   sp_reg <= sp_reg + 32'd1;
      2'b10:   sp_reg <= sp_reg - 32'd1;
      2'b11:   sp_reg <= SPSet;
      default: sp_reg <= sp_reg;
    endcase
  end

  assign mem_ack   = mem_req && (wait_cnt == ack_delay);
  assign mem_rdata = mem[mem_addr[12:0]];

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we) mem[mem_addr[12:0]] <= mem_wdata;
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  // Abstract stack semantics: result, final SP and latency of one op.
  task automatic model_op(input logic [1:0] code, input logic [31:0] data, input int delay);
    e_err = 2'b00; e_nreq = 0; e_addr = '0; e_wdata = '0; e_we = 1'b0; e_lat = 1;
    case (code)
      2'b00: begin
        if (sp_m == LIMIT) e_err = 2'b01;
        else begin
          sp_m = sp_m - 1;
          mm[sp_m[12:0]] = data;
          e_nreq = delay + 1; e_addr = sp_m; e_wdata = data; e_we = 1'b1;
          e_lat = 3 + delay;
        end
      end
      2'b10: begin
        if (data < LIMIT || data > BASE) e_err = 2'b11;
        else begin
          sp_m = data;
          e_lat = 2;
        end
      end
      default: begin
        if (sp_m == BASE) e_err = 2'b10;
        else begin
          rdata_m = mm[sp_m[12:0]];
          e_nreq = delay + 1; e_addr = sp_m;
          if (code == 2'b01) begin
            e_lat = 3 + delay;
            sp_m = sp_m + 1;
          end else e_lat = 2 + delay;
        end
      end
    endcase
    e_sp = sp_m;
    e_rdata = rdata_m;
  endtask

  // Issue one op and record what the DUT does; entered and left on a negedge.
  task automatic do_op(input logic [1:0] code, input logic [31:0] data, input int delay);
    int n;
    model_op(code, data, delay);
    ack_delay = delay;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    op_valid = 1'b1; op_code = code; op_data = data;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_data = $urandom;
    o_lat = 0; o_nreq = 0; o_stable = 1'b1; o_proto = 1'b0;
    o_err = 2'b00; o_rdata = '0; o_sp = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0;
    for (int c = 1; c <= 40 && o_lat == 0; c++) begin
      @(negedge clk);
      if (mem_req) begin
        if (o_nreq == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wdata || mem_we !== o_we)
          o_stable = 1'b0;
        o_nreq++;
      end
      if (done) begin
        o_lat = c; o_err = err; o_rdata = rdata; o_sp = sp_reg;
      end else if (op_ready || err != 2'b00) o_proto = 1'b1;
    end
    @(negedge clk);
    if (done || err != 2'b00) o_proto = 1'b1;
    o_ready_after = op_ready;
    ack_delay = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({op_ready, done, err, SPDrive, mem_req, mem_we} !== 8'h00 || rdata !== 32'h0 || SPSet !== BASE)
      $display("FAIL reset_outputs: ready=%b done=%b err=%b drv=%b req=%b we=%b rdata=%h spset=%h, required all 0 and spset=%h",
               op_ready, done, err, SPDrive, mem_req, mem_we, rdata, SPSet, BASE);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (SPDrive !== 2'b11 || SPSet !== BASE || op_ready !== 1'b0)
      $display("FAIL init_load: drv=%b spset=%h ready=%b, required 11 %h 0", SPDrive, SPSet, op_ready, BASE);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (SPDrive !== 2'b00 || sp_reg !== BASE || op_ready !== 1'b1)
      $display("FAIL init_idle: drv=%b sp=%h ready=%b, required 00 %h 1", SPDrive, sp_reg, op_ready, BASE);
    else pass_cnt++;
    sp_m = BASE;
    rdata_m = '0;
  endtask

  task automatic test_push_peek_pop();
    do_op(2'b00, 32'h0000_00A5, 0);
    chk_cnt++;
    if (o_lat !== 3 || o_err !== 2'b00 || o_addr !== 32'h0FFF || o_wdata !== 32'hA5 || o_we !== 1'b1 || o_sp !== 32'h0FFF)
      $display("FAIL push_a5: lat=%0d err=%b addr=%h wdata=%h we=%b sp=%h, required 3 00 0fff a5 1 0fff",
               o_lat, o_err, o_addr, o_wdata, o_we, o_sp);
    else pass_cnt++;
    do_op(2'b11, 32'h0, 0);
    chk_cnt++;
    if (o_lat !== 2 || o_rdata !== 32'hA5 || o_sp !== 32'h0FFF || o_we !== 1'b0 || o_addr !== 32'h0FFF)
      $display("FAIL peek: lat=%0d rdata=%h sp=%h we=%b addr=%h, required 2 a5 0fff 0 0fff", o_lat, o_rdata, o_sp, o_we, o_addr);
    else pass_cnt++;
    do_op(2'b01, 32'h0, 0);
    chk_cnt++;
    if (o_lat !== 3 || o_rdata !== 32'hA5 || o_sp !== BASE || o_err !== 2'b00)
      $display("FAIL pop: lat=%0d rdata=%h sp=%h err=%b, required 3 a5 1000 00", o_lat, o_rdata, o_sp, o_err);
    else pass_cnt++;
    chk_cnt++;
    if (o_proto !== 1'b0 || o_ready_after !== 1'b1)
      $display("FAIL pop_handshake: proto=%b ready_after=%b, required 0 1", o_proto, o_ready_after);
    else pass_cnt++;
  endtask

  task automatic test_faults();
    do_op(2'b01, 32'h0, 0);
    chk_cnt++;
    if (o_lat !== 1 || o_err !== 2'b10 || o_nreq !== 0 || o_sp !== BASE || o_rdata !== 32'hA5)
      $display("FAIL pop_empty: lat=%0d err=%b nreq=%0d sp=%h rdata=%h, required 1 10 0 1000 a5",
               o_lat, o_err, o_nreq, o_sp, o_rdata);
    else pass_cnt++;
    do_op(2'b10, LIMIT, 0);
    chk_cnt++;
    if (o_lat !== 2 || o_err !== 2'b00 || o_sp !== LIMIT)
      $display("FAIL load_limit: lat=%0d err=%b sp=%h, required 2 00 0f00", o_lat, o_err, o_sp);
    else pass_cnt++;
    do_op(2'b00, 32'hDEAD_BEEF, 0);
    chk_cnt++;
    if (o_lat !== 1 || o_err !== 2'b01 || o_nreq !== 0 || o_sp !== LIMIT)
      $display("FAIL push_full: lat=%0d err=%b nreq=%0d sp=%h, required 1 01 0 0f00", o_lat, o_err, o_nreq, o_sp);
    else pass_cnt++;
    do_op(2'b10, 32'h0000_2000, 0);
    chk_cnt++;
    if (o_lat !== 1 || o_err !== 2'b11 || o_sp !== LIMIT)
      $display("FAIL load_range: lat=%0d err=%b sp=%h, required 1 11 0f00", o_lat, o_err, o_sp);
    else pass_cnt++;
    do_op(2'b10, 32'h0000_0F80, 0);
    chk_cnt++;
    if (o_lat !== 2 || o_err !== 2'b00 || o_sp !== 32'h0F80)
      $display("FAIL load_f80: lat=%0d err=%b sp=%h, required 2 00 0f80", o_lat, o_err, o_sp);
    else pass_cnt++;
  endtask

  task automatic test_ack_delay();
    do_op(2'b00, 32'h1234_5678, 3);
    chk_cnt++;
    if (o_lat !== 6 || o_nreq !== 4 || o_stable !== 1'b1 || o_addr !== 32'h0F7F || o_wdata !== 32'h1234_5678)
      $display("FAIL push_wait: lat=%0d nreq=%0d stable=%b addr=%h wdata=%h, required 6 4 1 0f7f 12345678",
               o_lat, o_nreq, o_stable, o_addr, o_wdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int n;
    ack_delay = 8;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    op_valid = 1'b1; op_code = 2'b00; op_data = 32'h0000_0055;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL mid_reach_wr: req=%b we=%b, required 1 1", mem_req, mem_we);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (mem_req !== 1'b0 || done !== 1'b0 || SPDrive !== 2'b00)
      $display("FAIL mid_reset_async: req=%b done=%b drv=%b, required 0 0 00", mem_req, done, SPDrive);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (SPDrive !== 2'b11 || SPSet !== BASE || done !== 1'b0)
      $display("FAIL mid_init_load: drv=%b spset=%h done=%b, required 11 %h 0", SPDrive, SPSet, done, BASE);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (sp_reg !== BASE || op_ready !== 1'b1 || done !== 1'b0 || rdata !== 32'h0)
      $display("FAIL mid_recover: sp=%h ready=%b done=%b rdata=%h, required %h 1 0 0", sp_reg, op_ready, done, rdata, BASE);
    else pass_cnt++;
    ack_delay = 0;
    sp_m = BASE;
    rdata_m = '0;
  endtask

  task automatic test_random();
    logic [1:0]  code;
    logic [31:0] data;
    int          delay;
    for (int i = 0; i < 60; i++) begin
      code  = 2'($urandom_range(0, 3));
      delay = int'($urandom_range(0, 2));
      data  = (code == 2'b10) ? (32'h0000_0EF0 + 32'($urandom_range(0, 32'h130))) : 32'($urandom);
      do_op(code, data, delay);
      chk_cnt++;
      if (o_lat !== e_lat || o_err !== e_err || o_sp !== e_sp || o_rdata !== e_rdata)
        $display("FAIL rand_result[%0d] op=%b: lat=%0d err=%b sp=%h rdata=%h, required %0d %b %h %h",
                 i, code, o_lat, o_err, o_sp, o_rdata, e_lat, e_err, e_sp, e_rdata);
      else pass_cnt++;
      chk_cnt++;
      if (o_nreq !== e_nreq || (e_nreq != 0 && (o_addr !== e_addr || o_we !== e_we)) ||
          (e_we && o_wdata !== e_wdata))
        $display("FAIL rand_mem[%0d] op=%b: nreq=%0d addr=%h we=%b wdata=%h, required %0d %h %b %h",
                 i, code, o_nreq, o_addr, o_we, o_wdata, e_nreq, e_addr, e_we, e_wdata);
      else pass_cnt++;
      chk_cnt++;
      if (o_stable !== 1'b1 || o_proto !== 1'b0 || o_ready_after !== 1'b1)
        $display("FAIL rand_proto[%0d]: stable=%b proto=%b ready_after=%b, required 1 0 1",
                 i, o_stable, o_proto, o_ready_after);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i] = '0;
      mm[i]  = '0;
    end
    sp_m = BASE;
    rdata_m = '0;
    test_reset();
    test_push_peek_pop();
    test_faults();
    test_ack_delay();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sp_ctrl.md
# sp_ctrl

Stack sequencer that owns the `SP` stack-pointer register and a single-port word-addressed data memory port. It accepts PUSH/POP/PEEK/LOAD requests from the core through a valid/ready handshake and drives `SPDrive`/`SPSet` in the correct order around the memory access. It checks stack bounds before touching SP or memory. It also initialises SP to the empty value after reset.

## Interface
- `WIDTH`, 32: SP, address and data width.
- `STACK_BASE`, 32'h0000_1000: empty-stack SP value (full-descending stack).
- `STACK_LIMIT`, 32'h0000_0F00: lowest legal SP; capacity = `STACK_BASE - STACK_LIMIT` words.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  request valid.
- `op_code`  in  2  00 PUSH, 01 POP, 10 LOAD, 11 PEEK.
- `op_data`  in  WIDTH  PUSH data or LOAD value.
- `op_ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  2  valid with `done`: 00 ok, 01 overflow, 10 underflow, 11 LOAD out of range.
- `rdata`  out  WIDTH  POP/PEEK result; held until the next successful POP/PEEK.
- `SPDrive`  out  2  to SP: 00 hold, 01 increment, 10 decrement, 11 load `SPSet`.
- `SPSet`  out  WIDTH  load value to SP.
- `SPOutput`  in  WIDTH  current SP from SP.
- `mem_req`, `mem_we`  out  1  memory request and write enable.
- `mem_addr`, `mem_wdata`  out  WIDTH  memory address and write data.
- `mem_rdata`  in  WIDTH  read data, valid with `mem_ack`.
- `mem_ack`  in  1  completes the request; may arrive in the same cycle as `mem_req` or later.

## Operation
- States: INIT, IDLE, DEC, WR, RD, INC, LD, RESP.
- Reset takes effect immediately: state INIT. All outputs are 0 except `SPSet` = `STACK_BASE`. `rdata` = 0.
- INIT, 1 cycle: `SPDrive`=11, `SPSet`=`STACK_BASE`, then IDLE.
- IDLE: `op_ready`=1. An op is accepted when `op_valid & op_ready`. On accept, latch `op_code` and `op_data`, then check bounds against `SPOutput`:
  - PUSH with SP == `STACK_LIMIT`: err 01.
  - POP or PEEK with SP == `STACK_BASE`: err 10.
  - LOAD with `op_data` < `STACK_LIMIT` or > `STACK_BASE`: err 11.
  - On any fault, go straight to RESP. SP, memory and `rdata` are not touched.
- PUSH: DEC (`SPDrive`=10) → WR (`mem_req`=1, `mem_we`=1, `mem_addr`=`SPOutput` (already decremented), `mem_wdata`=latched data; hold until `mem_ack`) → RESP.
- POP: RD (`mem_req`=1, `mem_we`=0, `mem_addr`=`SPOutput`; hold until `mem_ack`; capture `mem_rdata` into `rdata`) → INC (`SPDrive`=01) → RESP.
- PEEK: RD → RESP. SP is unchanged.
- LOAD: LD (`SPDrive`=11, `SPSet`=latched data) → RESP.
- RESP: `done`=1 and `err` is valid for exactly 1 cycle, then IDLE. `err` is 00 outside RESP.
- `SPDrive` is 00 in every state not listed above.
- `mem_addr` and `mem_wdata` stay stable while `mem_req` is high.
- Reset mid-operation: the op is abandoned, `mem_req` drops immediately, no `done`, and the INIT load is re-run.

## Timing
- Accept at cycle T. Latencies with `mem_ack` in the same cycle as `mem_req`:
  - PUSH: `done` at T+3.
  - POP: `done` at T+3.
  - PEEK: `done` at T+2.
  - LOAD: `done` at T+2.
  - Fault: `done` at T+1.
- Each extra wait cycle on `mem_ack` adds 1 cycle.
- `op_ready` is first high 1 cycle after reset release (INIT occupies the first cycle).
- `op_ready` drops in the cycle after accept. The earliest next accept is the cycle after `done`.
- SP changes at the clock edge ending DEC, INC, LD or INIT. The following state sees the new `SPOutput`.

## Test plan
- Reset, then idle 2 cycles → `SPDrive`=11 with `SPSet`=0x1000 for 1 cycle; `SPOutput`=0x1000; `op_ready`=1 at cycle 2.
- PUSH 0xA5, then PEEK, then POP → write to addr 0xFFF with `done` at T+3; PEEK `rdata`=0xA5 with SP at 0xFFF; POP `rdata`=0xA5 and SP back to 0x1000.
- POP on an empty stack → `done` at T+1, `err`=10, no `mem_req`, SP stays 0x1000. Then LOAD 0xF00 followed by PUSH → `err`=01 and SP stays 0xF00.
- LOAD 0x2000 → `err`=11 and SP unchanged. LOAD 0xF80 → `err`=00 and `SPOutput`=0xF80 at T+2.
- PUSH with `mem_ack` delayed 3 cycles → `mem_req`/`mem_addr`/`mem_wdata` stable for 4 cycles; `done` at T+6.
- Assert `rst` during WR → `mem_req` low immediately, no `done`, INIT reload to 0x1000.
